// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan driver and its hex decoder.
package sseg_scan_ctrl_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n = hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/sseg_scan_ctrl_hex.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_sseg
    import sseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment driver with double-buffered value,
// per-digit decimal points and optional leading-zero blanking.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] VALUE,
    input  logic        LOAD,
    input  logic [3:0]  DP_IN,
    input  logic        BLANK_LZ,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        FRAME_TICK
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [IW-1:0] idx, idx_nxt;
    logic          boundary;
    logic [15:0]   shadow_val, disp_val, disp_nxt;
    logic [3:0]    shadow_dp, disp_dp, dp_nxt;
    logic [3:0]    nib;
    logic [6:0]    seg_pat;
    logic          blank;

    assign tick     = (cnt == CW'(PRESCALE - 1));
    assign idx_nxt  = idx + 1'b1;
    assign boundary = tick && (idx_nxt == '0);

    // Digit 0 must already see the freshly latched frame, so the output
    // path looks through the display register on the boundary tick.
    assign disp_nxt = boundary ? shadow_val : disp_val;
    assign dp_nxt   = boundary ? shadow_dp  : disp_dp;
    assign nib      = disp_nxt[{idx_nxt, 2'b00} +: 4];

    hex_to_sseg u_hex (
        .nib (nib),
        .seg (seg_pat)
    );

    // Prescaler: one tick every PRESCALE cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + 1'b1;
    end

    // Digit index; starts at 3 so the first tick lands on digit 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       idx <= IW'(NUM_DIGITS - 1);
        else if (tick) idx <= idx_nxt;
    end

    // Shadow capture on LOAD; display takes the shadow only at frame start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else begin
            if (LOAD) begin
                shadow_val <= VALUE;
                shadow_dp  <= DP_IN;
            end
            if (boundary) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
        end
    end

    // Leading-zero blanking: digit blanked when it and everything above is 0.
    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (idx_nxt)
                2'd1:    blank = (disp_nxt[15:4]  == '0);
                2'd2:    blank = (disp_nxt[15:8]  == '0);
                2'd3:    blank = (disp_nxt[15:12] == '0);
                default: blank = 1'b0;
            endcase
        end
    end

    // Registered pin drivers, updated on the tick edge from the next index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AN  <= AN_OFF;
            SEG <= SEG_OFF;
            DP  <= 1'b1;
        end else if (tick) begin
            AN  <= ~(4'b0001 << idx_nxt);
            SEG <= blank ? SEG_OFF : seg_pat;
            DP  <= blank | ~dp_nxt[idx_nxt];
        end
    end

    // Frame pulse, high for the cycle after the index moves to digit 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) FRAME_TICK <= 1'b0;
        else     FRAME_TICK <= boundary;
    end

endmodule
